// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter among NREQ requesters,
// optionally prefixing each data byte with a source-identifying header byte.
module uart_tx_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter bit          HDR_EN   = 1'b1,
    parameter logic [7:0]  HDR_BASE = 8'hA0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] req_data_i,
    output logic [NREQ-1:0]   req_ack_o,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_busy_i,
    output logic [2:0]        grant_id_o,
    output logic              busy_o
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IDW  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_HDR,
        WAIT_HDR,
        SEND_DATA,
        WAIT_DATA,
        ACK
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [NREQ-1:0]   req_ack_q, req_ack_d;
    logic              busy_q, busy_d;
    logic [7:0]        data_lat_q, data_lat_d;
    logic              seen_busy_q, seen_busy_d;

    logic [7:0]        req_bytes [NREQ];
    logic              win_found;
    logic [IDXW-1:0]   win_idx;
    logic [IDXW-1:0]   cand;

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data_i[8*g +: 8];
    end

    // First requester at or after rr_ptr+1, searching upward with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDXW'((32'(rr_ptr_q) + k) % NREQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            grant_id_q  <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'hFF;
            req_ack_q   <= '0;
            busy_q      <= 1'b0;
            data_lat_q  <= 8'hFF;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            req_ack_q   <= req_ack_d;
            busy_q      <= busy_d;
            data_lat_q  <= data_lat_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    // Outputs are computed for the state being entered so they line up with it.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        req_ack_d   = '0;
        data_lat_d  = data_lat_q;
        seen_busy_d = seen_busy_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_id_d = IDW'(win_idx);
                    rr_ptr_d   = IDW'(win_idx);
                    data_lat_d = req_bytes[win_idx];
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                tx_start_d = 1'b1;
                if (HDR_EN) begin
                    tx_data_d = HDR_BASE + 8'(grant_id_q);
                    state_d   = SEND_HDR;
                end else begin
                    tx_data_d = data_lat_q;
                    state_d   = SEND_DATA;
                end
            end
            SEND_HDR: begin
                seen_busy_d = 1'b0;
                state_d     = WAIT_HDR;
            end
            WAIT_HDR: begin
                if (tx_busy_i) begin
                    seen_busy_d = 1'b1;
                end
                if (seen_busy_q && !tx_busy_i) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = data_lat_q;
                    state_d    = SEND_DATA;
                end
            end
            SEND_DATA: begin
                seen_busy_d = 1'b0;
                state_d     = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (tx_busy_i) begin
                    seen_busy_d = 1'b1;
                end
                if (seen_busy_q && !tx_busy_i) begin
                    for (int unsigned k = 0; k < NREQ; k++) begin
                        req_ack_d[k] = (grant_id_q == IDW'(k));
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign req_ack_o  = req_ack_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: three instances (header on, header off,
// wrapping header base), each with a simple busy-counter transmitter model.
module tb_uart_tx_arbiter;

    logic              clk;
    logic              rst;
    logic [2:0][3:0]   req_a;
    logic [2:0][31:0]  data_a;
    logic [2:0][3:0]   ack_a;
    logic [2:0]        tx_start_a;
    logic [2:0][7:0]   tx_data_a;
    logic [2:0]        tx_busy_a;
    logic [2:0][2:0]   grant_a;
    logic [2:0]        busy_a;

    int                tests;
    int                fails;
    logic [15:0]       exp_q [3][$];

    uart_tx_arbiter #(.NREQ(4), .HDR_EN(1'b1), .HDR_BASE(8'hA0)) u0 (
        .clk(clk), .rst(rst), .req_i(req_a[0]), .req_data_i(data_a[0]),
        .req_ack_o(ack_a[0]), .tx_start_o(tx_start_a[0]), .tx_data_o(tx_data_a[0]),
        .tx_busy_i(tx_busy_a[0]), .grant_id_o(grant_a[0]), .busy_o(busy_a[0]));

    uart_tx_arbiter #(.NREQ(4), .HDR_EN(1'b0), .HDR_BASE(8'hA0)) u1 (
        .clk(clk), .rst(rst), .req_i(req_a[1]), .req_data_i(data_a[1]),
        .req_ack_o(ack_a[1]), .tx_start_o(tx_start_a[1]), .tx_data_o(tx_data_a[1]),
        .tx_busy_i(tx_busy_a[1]), .grant_id_o(grant_a[1]), .busy_o(busy_a[1]));

    uart_tx_arbiter #(.NREQ(4), .HDR_EN(1'b1), .HDR_BASE(8'hFE)) u2 (
        .clk(clk), .rst(rst), .req_i(req_a[2]), .req_data_i(data_a[2]),
        .req_ack_o(ack_a[2]), .tx_start_o(tx_start_a[2]), .tx_data_o(tx_data_a[2]),
        .tx_busy_i(tx_busy_a[2]), .grant_id_o(grant_a[2]), .busy_o(busy_a[2]));

    always #5 clk = ~clk;

    // Transmitter model: busy rises the edge after tx_start, stays up BL cycles.
    for (genvar g = 0; g < 3; g++) begin : g_txm
        localparam int unsigned BL = (g == 0) ? 20 : 5;
        int unsigned cnt;
        always @(posedge clk or negedge rst) begin
            if (!rst)                 cnt <= 0;
            else if (tx_start_a[g])   cnt <= BL;
            else if (cnt != 0)        cnt <= cnt - 1;
        end
        assign tx_busy_a[g] = (cnt != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input int k, input logic [15:0] obs);
        logic [15:0] e;
        tests++;
        if (exp_q[k].size() == 0) begin
            fails++;
            $display("FAIL sb%0d unexpected event: got %h, expected none", k, obs);
        end else begin
            e = exp_q[k].pop_front();
            if (e !== obs) begin
                fails++;
                $display("FAIL sb%0d event: got %h, expected %h", k, obs, e);
            end
        end
    endtask

    // Monitor: every tx_start is {01,byte}, every ack pulse is {02,0,ack}.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (tx_start_a[k])   sb_check(k, {8'h01, tx_data_a[k]});
                if (ack_a[k] != 4'h0) sb_check(k, {8'h02, 4'h0, ack_a[k]});
            end
        end
    endtask

    task automatic push_xfer(input int k, input logic [7:0] hdr, input bit has_hdr,
                             input logic [7:0] d, input bit has_ack, input logic [3:0] ack);
        if (has_hdr) exp_q[k].push_back({8'h01, hdr});
        exp_q[k].push_back({8'h01, d});
        if (has_ack) exp_q[k].push_back({8'h02, 4'h0, ack});
    endtask

    task automatic wait_ack(input int k);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (ack_a[k] != 4'h0) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_ack%0d timeout: got no ack, expected an ack", k);
        end
    endtask

    task automatic wait_tx(input int k);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (tx_start_a[k]) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_tx%0d timeout: got no tx_start, expected one", k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b0;
        tests  = 0;
        fails  = 0;
        req_a  = '0;
        data_a = '0;
        fork
            monitor();
        join_none

        // Reset with all requesting: outputs at reset values, then grant 0 first.
        req_a[0]  = 4'b1111;
        data_a[0] = 32'h44332211;
        repeat (3) @(negedge clk);
        chk("rst tx_start", 32'(tx_start_a[0]), 32'h0);
        chk("rst tx_data",  32'(tx_data_a[0]),  32'hFF);
        chk("rst req_ack",  32'(ack_a[0]),      32'h0);
        chk("rst busy",     32'(busy_a[0]),     32'h0);
        chk("rst grant_id", 32'(grant_a[0]),    32'h0);
        push_xfer(0, 8'hA0, 1'b1, 8'h11, 1'b1, 4'b0001);
        rst = 1'b1;
        wait_ack(0);
        req_a[0] = 4'b0000;
        chk("first grant_id", 32'(grant_a[0]), 32'h0);

        // Single request 2 with header; check 2-cycle grant-to-start latency.
        repeat (3) @(negedge clk);
        data_a[0][23:16] = 8'h5A;
        push_xfer(0, 8'hA2, 1'b1, 8'h5A, 1'b1, 4'b0100);
        req_a[0] = 4'b0100;
        @(negedge clk);
        chk("single lat c1 tx_start", 32'(tx_start_a[0]), 32'h0);
        @(negedge clk);
        chk("single lat c2 tx_start", 32'(tx_start_a[0]), 32'h1);
        chk("single hdr tx_data",     32'(tx_data_a[0]),  32'hA2);
        wait_ack(0);
        req_a[0] = 4'b0000;
        repeat (2) @(negedge clk);
        chk("single idle busy", 32'(busy_a[0]), 32'h0);

        // Round robin over 1011 starting from a fresh pointer.
        do_reset();
        data_a[0] = 32'h44332211;
        push_xfer(0, 8'hA0, 1'b1, 8'h11, 1'b1, 4'b0001);
        push_xfer(0, 8'hA1, 1'b1, 8'h22, 1'b1, 4'b0010);
        push_xfer(0, 8'hA3, 1'b1, 8'h44, 1'b1, 4'b1000);
        push_xfer(0, 8'hA0, 1'b1, 8'h11, 1'b1, 4'b0001);
        push_xfer(0, 8'hA1, 1'b1, 8'h22, 1'b1, 4'b0010);
        push_xfer(0, 8'hA3, 1'b1, 8'h44, 1'b1, 4'b1000);
        req_a[0] = 4'b1011;
        for (int n = 0; n < 6; n++) wait_ack(0);
        req_a[0] = 4'b0000;
        chk("rr last grant_id", 32'(grant_a[0]), 32'h3);

        // Request 1 arrives during requester 0's data wait: served only afterwards.
        repeat (3) @(negedge clk);
        push_xfer(0, 8'hA0, 1'b1, 8'h11, 1'b1, 4'b0001);
        push_xfer(0, 8'hA1, 1'b1, 8'h22, 1'b1, 4'b0010);
        req_a[0] = 4'b0001;
        wait_tx(0);
        wait_tx(0);
        repeat (3) @(negedge clk);
        req_a[0] = 4'b0011;
        repeat (2) @(negedge clk);
        chk("late req grant_id", 32'(grant_a[0]), 32'h0);
        chk("late req busy",     32'(busy_a[0]),  32'h1);
        wait_ack(0);
        req_a[0] = 4'b0010;
        wait_ack(0);
        req_a[0] = 4'b0000;

        // Requester 0 drops req after the header: latched byte still sent and acked.
        repeat (3) @(negedge clk);
        data_a[0][7:0] = 8'h5C;
        push_xfer(0, 8'hA0, 1'b1, 8'h5C, 1'b1, 4'b0001);
        req_a[0] = 4'b0001;
        wait_tx(0);
        req_a[0] = 4'b0000;
        data_a[0][7:0] = 8'hFF;
        wait_ack(0);
        data_a[0][7:0] = 8'h11;

        // Reset during the data wait: no ack, pointer restarts so id 0 wins next.
        repeat (3) @(negedge clk);
        data_a[0][23:16] = 8'h77;
        push_xfer(0, 8'hA2, 1'b1, 8'h77, 1'b0, 4'b0000);
        req_a[0] = 4'b0100;
        wait_tx(0);
        wait_tx(0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst tx_start", 32'(tx_start_a[0]), 32'h0);
        chk("midrst tx_data",  32'(tx_data_a[0]),  32'hFF);
        chk("midrst req_ack",  32'(ack_a[0]),      32'h0);
        chk("midrst busy",     32'(busy_a[0]),     32'h0);
        chk("midrst grant_id", 32'(grant_a[0]),    32'h0);
        req_a[0] = 4'b1111;
        push_xfer(0, 8'hA0, 1'b1, 8'h11, 1'b1, 4'b0001);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_ack(0);
        req_a[0] = 4'b0000;

        // No header: only the data byte, two cycles after the request.
        data_a[1][15:8] = 8'h3C;
        push_xfer(1, 8'h00, 1'b0, 8'h3C, 1'b1, 4'b0010);
        @(negedge clk);
        req_a[1] = 4'b0010;
        @(negedge clk);
        chk("nohdr c1 tx_start", 32'(tx_start_a[1]), 32'h0);
        @(negedge clk);
        chk("nohdr c2 tx_start", 32'(tx_start_a[1]), 32'h1);
        chk("nohdr tx_data",     32'(tx_data_a[1]),  32'h3C);
        wait_ack(1);
        req_a[1] = 4'b0000;

        // Header base FE with id 3 wraps to 01.
        data_a[2][31:24] = 8'h99;
        push_xfer(2, 8'h01, 1'b1, 8'h99, 1'b1, 4'b1000);
        req_a[2] = 4'b1000;
        wait_ack(2);
        req_a[2] = 4'b0000;

        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("sb%0d drained", k), 32'(exp_q[k].size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
